// File: rtl/data_mem_responder_pkg.sv
// Shared types and default widths for the multi-channel data memory responder.
package data_mem_responder_pkg;
  localparam int DEF_ADDR_BITS    = 8;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_NUM_CHANNELS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_RESP = 2'd1,
    WR_RESP = 2'd2,
    HOLD    = 2'd3
  } chan_state_t;
endpackage

// File: rtl/data_mem_responder_rr_arbiter.sv
// Round-robin arbiter: one-hot grant per cycle, priority rotates to the channel after the last winner.
module rr_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant
);
  localparam int PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  int               idx;

  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    idx      = 0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= WIDTH) idx = idx - WIDTH;
      if (req[idx] && (grant == '0)) begin
        grant[idx] = 1'b1;
        ptr_next   = (idx == WIDTH - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_next;
  end
endmodule

// File: rtl/data_mem_responder.sv
// Multi-channel memory responder: per-channel handshake FSMs share one read and one write port
// through independent round-robin arbiters; a host port preloads storage with top write priority.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready,
  input  logic                    host_write_en,
  input  logic [ADDR_BITS-1:0]    host_write_address,
  input  logic [DATA_BITS-1:0]    host_write_data
);
  chan_state_t             state      [NUM_CHANNELS];
  chan_state_t             state_next [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] rd_req, wr_req, rd_grant, wr_grant;
  logic [DATA_BITS-1:0]    mem        [2**ADDR_BITS];
  logic [DATA_BITS-1:0]    rd_data    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    rd_addr, wr_addr;
  logic [DATA_BITS-1:0]    wr_data;
  logic                    wr_en;

  // A pending read masks the write on the same channel; a host write blocks all channel writes.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rd_req[i] = !reset && (state[i] == IDLE) && mem_read_valid[i];
      wr_req[i] = !reset && !host_write_en && (state[i] == IDLE) &&
                  mem_write_valid[i] && !mem_read_valid[i];
    end
  end

  rr_arbiter #(.WIDTH(NUM_CHANNELS)) u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .req   (rd_req),
    .grant (rd_grant)
  );

  rr_arbiter #(.WIDTH(NUM_CHANNELS)) u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .req   (wr_req),
    .grant (wr_grant)
  );

  always_comb begin
    rd_addr = '0;
    wr_addr = host_write_address;
    wr_data = host_write_data;
    wr_en   = host_write_en;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_grant[i]) rd_addr = mem_read_address[i];
      if (wr_grant[i]) begin
        wr_addr = mem_write_address[i];
        wr_data = mem_write_data[i];
        wr_en   = 1'b1;
      end
    end
  end

  // Same-edge read and write to one address returns the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (reset)            rd_data[i] <= '0;
      else if (rd_grant[i]) rd_data[i] <= mem[rd_addr];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_next[i] = state[i];
      case (state[i])
        IDLE: begin
          if (rd_grant[i])      state_next[i] = RD_RESP;
          else if (wr_grant[i]) state_next[i] = WR_RESP;
        end
        RD_RESP: state_next[i] = HOLD;
        WR_RESP: state_next[i] = HOLD;
        HOLD: begin
          if (!mem_read_valid[i] && !mem_write_valid[i]) state_next[i] = IDLE;
        end
        default: state_next[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (reset) state[i] <= IDLE;
      else       state[i] <= state_next[i];
    end
  end

  // Outputs are masked by reset so an aborted transaction never shows a strobe.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      mem_read_ready[i]  = !reset && (state[i] == RD_RESP);
      mem_write_ready[i] = !reset && (state[i] == WR_RESP);
      mem_read_data[i]   = reset ? '0 : rd_data[i];
    end
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be: ADDR_BITS, default 8, address width; DATA_BITS, default 8, word width; NUM_CHANNELS, default 4, number of GPU memory channels served.
REQ-002 clk  input  1  single clock; every state element SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_read_valid  input  NUM_CHANNELS  per-channel read request.
REQ-005 mem_read_address  input  ADDR_BITS x NUM_CHANNELS (unpacked)  per-channel read address.
REQ-006 mem_read_ready  output  NUM_CHANNELS  per-channel read-complete strobe.
REQ-007 mem_read_data  output  DATA_BITS x NUM_CHANNELS (unpacked)  per-channel read data; valid while the matching ready is high.
REQ-008 mem_write_valid, mem_write_address, mem_write_data  input  NUM_CHANNELS / ADDR_BITS x N / DATA_BITS x N  per-channel write request.
REQ-009 mem_write_ready  output  NUM_CHANNELS  per-channel write-complete strobe.
REQ-010 host_write_en, host_write_address, host_write_data  input  1 / ADDR_BITS / DATA_BITS  preload port for the bench or host.

Function
REQ-011 Storage SHALL be 2^ADDR_BITS words of DATA_BITS bits, with one read and one write per cycle; storage SHALL NOT be reset.
REQ-012 Each channel SHALL run its own FSM with states IDLE, RD_RESP, WR_RESP and HOLD.
REQ-013 A channel in IDLE with valid high SHALL be eligible for arbitration in the same cycle.
REQ-014 Read arbitration SHALL be round-robin among eligible read channels, with one grant per cycle.
REQ-015 Write arbitration SHALL be an independent round-robin, with one grant per cycle.
REQ-016 Each round-robin pointer SHALL reset to 0; after a grant to channel k, channel (k+1) mod NUM_CHANNELS SHALL have highest priority.
REQ-017 A granted read SHALL latch storage[address] at the grant edge and move the channel to RD_RESP.
REQ-018 In RD_RESP, mem_read_ready SHALL be high for exactly one cycle with the latched data, then the channel SHALL move to HOLD; minimum latency is valid at cycle 0, ready at cycle 1.
REQ-019 A granted write SHALL commit at the grant edge and move the channel to WR_RESP, where mem_write_ready SHALL pulse for one cycle; the channel SHALL then move to HOLD.
REQ-020 In HOLD, the channel SHALL return to IDLE only once both of its valids are low, so a still-high valid is never serviced twice.
REQ-021 If a channel in IDLE has read and write valid together, the read SHALL be served first; the write SHALL be served on a later visit to IDLE.
REQ-022 A read and a write to the same address granted in the same cycle SHALL return the old data (read-before-write).
REQ-023 A host write SHALL take precedence over a channel write in the same cycle; the channel write SHALL stay ungranted and retry.
REQ-024 mem_read_data SHALL hold its last value while mem_read_ready is low.
REQ-025 Ungranted channels SHALL wait indefinitely with no timeout.
REQ-026 Address arithmetic SHALL NOT occur; the full ADDR_BITS range SHALL be reachable.

Reset
REQ-027 While reset is high, all FSMs SHALL be IDLE, all ready outputs 0, all read_data 0, and both pointers 0.
REQ-028 Asserting reset mid-transaction SHALL abort the transaction: no ready pulse afterwards, and no storage write at that edge other than a host write.

Structure
REQ-029 A shared package SHALL hold the channel-state enum and the default width constants.
REQ-030 One sub-module, rr_arbiter (parameterised width; request in, one-hot grant out, pointer register), SHALL be instantiated twice: once for reads and once for writes.

Verification
REQ-031 Preload storage[0x10]=0x5A via the host port; ch0 reads 0x10 at cycle 0 -> ch0 read_ready pulses at cycle 1 with 0x5A, exactly once while valid stays high.
REQ-032 All four channels raise read_valid in the same cycle after reset -> ready at cycles 1, 2, 3, 4 in order ch0, ch1, ch2, ch3; a repeat burst starts at ch0 after the pointer wraps.
REQ-033 ch2 writes 0x33 to 0x20 -> write_ready at +1; ch1 then reads 0x20 -> data 0x33.
REQ-034 With storage[0x40]=0x11, ch0 writes 0x22 to 0x40 and ch1 reads 0x40 in the same cycle -> ch1 gets 0x11; a later read returns 0x22.
REQ-035 Reset asserted in the cycle after a read grant -> no ready pulse, and all outputs are 0 on the next cycle.
REQ-036 Host write and ch3 write hit the same cycle -> the host data lands first; ch3 completes one cycle later and its data is the final value.
